// File: rtl/pheap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pheap_ctrl_pkg
// Brief    : Shared pipelined-heap types: opcodes, level status, value word.
// Revision : 1.0
// ============================================================================
package pheap_ctrl_pkg;

    typedef enum logic [0:0] {
        LEQ = 1'b0,
        DEQ = 1'b1
    } opcode_t;

    typedef enum logic [1:0] {
        WAIT       = 2'd0,
        DONE       = 2'd1,
        NEXT_LEVEL = 2'd2
    } done_t;

    typedef logic [31:0] pValue;

endpackage
`default_nettype wire

// File: rtl/pheap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pheap_ctrl
// Brief    : Host-side controller for a pipelined heap; issues ops to level 1,
//            tracks occupancy and spaces operations apart with a gap counter.
// Revision : 1.0
// ============================================================================
module pheap_ctrl
    import pheap_ctrl_pkg::*;
#(
    parameter int LEVELS = 4,
    parameter int GAP    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  opcode_t         req_op,
    input  pValue           req_value,
    output logic            resp_valid,
    output pValue           resp_value,
    output logic            resp_err,
    output logic [LEVELS:0] count,
    output logic            lvl_start,
    output opcode_t         lvl_op,
    output pValue           lvl_in,
    input  done_t           lvl_done,
    input  pValue           lvl_out
);

    localparam logic [LEVELS:0] C_CAP      = (LEVELS+1)'((1 << LEVELS) - 1);
    localparam int              C_GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [C_GW-1:0] C_GAP_LOAD = C_GW'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_L1 = 3'd2,
        S_RESP    = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t          r_state;
    logic [LEVELS:0] r_count;
    logic [C_GW-1:0] r_gap;
    opcode_t         r_op;
    pValue           r_val;
    logic            r_err;

    logic            w_active;
    logic            w_illegal;

    assign w_illegal = ((req_op == LEQ) && (r_count == C_CAP)) ||
                       ((req_op == DEQ) && (r_count == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_gap   <= '0;
            r_op    <= LEQ;
            r_val   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (w_illegal) begin
                            r_err   <= 1'b1;
                            r_val   <= '0;
                            r_state <= S_RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_op    <= req_op;
                            r_val   <= req_value;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: r_state <= S_WAIT_L1;
                S_WAIT_L1: begin
                    if (lvl_done != WAIT) begin
                        // r_val switches from the issued operand to the response value here
                        r_val   <= (r_op == DEQ) ? lvl_out : '0;
                        r_count <= (r_op == DEQ) ? r_count - 1'b1 : r_count + 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (r_err) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap   <= C_GAP_LOAD;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode the registered state; rst masks them during reset.
    assign w_active   = (r_state == S_ISSUE) || (r_state == S_WAIT_L1);
    assign req_ready  = !rst && (r_state == S_IDLE);
    assign lvl_start  = !rst && (r_state == S_ISSUE);
    assign lvl_op     = (!rst && w_active) ? r_op : LEQ;
    assign lvl_in     = (!rst && w_active) ? r_val : '0;
    assign resp_valid = !rst && (r_state == S_RESP);
    assign resp_err   = !rst && (r_state == S_RESP) && r_err;
    assign resp_value = (!rst && (r_state == S_RESP)) ? r_val : '0;
    assign count      = r_count;

endmodule
`default_nettype wire
